uart_autobaud_ctrl: RTL

//  Auto-baud controller that configures the shared UART baud rate generator.
//  On request, it measures the start bit and bit 0 of a 0x55 sync character on RX.
//  It classifies the measured bit period as 1200/2400/4800/9600 baud and drives the
//  2-bit rate select into the generator. It pulses a generator reset so tick phase

---
 rtl/uart_autobaud_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl
//   Auto-baud controller for the shared UART baud rate generator. On i_start it
//   measures the low start bit and the high bit 0 of a 0x55 sync character,
//   classifies both periods into 1200/2400/4800/9600 baud, and, if they agree,
//   drives the new rate select and pulses a generator reset.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for i_start
//   ARM       | waiting for the line to be idle (high) for one cycle
//   WAIT_FALL | waiting for the start-bit falling edge (no timeout)
//   MEAS_LOW  | counting the start bit (low)
//   MEAS_HIGH | counting bit 0 (high)
//   CHECK     | classify both periods and compare
//   DONE      | rate accepted: update rate, pulse o_gen_rst / o_done
//   FAIL      | rate rejected: pulse o_err
//
// Ports
//   i_clk      system clock (100 MHz nominal)
//   i_reset    asynchronous active-high reset
//   i_start    1-cycle pulse: begin or restart detection
//   i_rx       raw asynchronous RX line, idle high
//   o_bd_rate  rate select (00=1200, 01=2400, 10=4800, 11=9600)
//   o_gen_rst  1-cycle generator reset on rate update
//   o_busy     high whenever not IDLE
//   o_locked   valid rate detected since the last start
//   o_done     1-cycle success pulse
//   o_err      1-cycle failure pulse
module uart_autobaud_ctrl #(
  parameter int         MIN_CYC      = 5208,
  parameter int         TH_96_48     = 15625,
  parameter int         TH_48_24     = 31250,
  parameter int         TH_24_12     = 62500,
  parameter int         MAX_CYC      = 125000,
  parameter logic [1:0] DEFAULT_RATE = 2'b11
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_rx,
  output logic [1:0] o_bd_rate,
  output logic       o_gen_rst,
  output logic       o_busy,
  output logic       o_locked,
  output logic       o_done,
  output logic       o_err
);

  localparam logic [16:0] MIN_C   = 17'(MIN_CYC);
  localparam logic [16:0] TH_A    = 17'(TH_96_48);
  localparam logic [16:0] TH_B    = 17'(TH_48_24);
  localparam logic [16:0] TH_C    = 17'(TH_24_12);
  localparam logic [16:0] MAX_C   = 17'(MAX_CYC);
  localparam logic [16:0] CNT_SAT = 17'(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_FALL, MEAS_LOW, MEAS_HIGH, CHECK, DONE, FAIL
  } state_t;

  state_t      state, state_nxt;
  logic [16:0] cnt, cnt_nxt, cnt_inc;
  logic [16:0] low_cnt, low_nxt, high_cnt, high_nxt;
  logic [1:0]  cls_q;
  logic        rx_meta, rx_s, rx_d;
  logic        rx_fall, rx_rise;
  logic [2:0]  cls_low, cls_high;

  // Returns {valid, rate}.
  function automatic logic [2:0] cls(input logic [16:0] n);
    if (n < MIN_C)       cls = 3'b0_00;
    else if (n < TH_A)   cls = 3'b1_11;
    else if (n < TH_B)   cls = 3'b1_10;
    else if (n < TH_C)   cls = 3'b1_01;
    else if (n <= MAX_C) cls = 3'b1_00;
    else                 cls = 3'b0_00;
  endfunction

  // RX synchronizer plus one history flop for edge detection; idle-high reset
  // so no phantom edge appears out of reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign rx_fall  = rx_d & ~rx_s;
  assign rx_rise  = ~rx_d & rx_s;
  assign cls_low  = cls(low_cnt);
  assign cls_high = cls(high_cnt);
  assign cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + 17'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    low_nxt   = low_cnt;
    high_nxt  = high_cnt;
    case (state)
      IDLE:      if (i_start) state_nxt = ARM;
      ARM:       if (rx_s) state_nxt = WAIT_FALL;
      WAIT_FALL: if (rx_fall) state_nxt = MEAS_LOW;
      MEAS_LOW: begin
        if (cnt == CNT_SAT) state_nxt = FAIL;
        else if (rx_rise) begin
          low_nxt   = cnt;
          state_nxt = MEAS_HIGH;
        end else if (!rx_s) cnt_nxt = cnt_inc;
      end
      MEAS_HIGH: begin
        if (cnt == CNT_SAT) state_nxt = FAIL;
        else if (rx_fall) begin
          high_nxt  = cnt;
          state_nxt = CHECK;
        end else if (rx_s) cnt_nxt = cnt_inc;
      end
      CHECK: begin
        if (cls_low[2] && cls_high[2] && (cls_low[1:0] == cls_high[1:0]))
          state_nxt = DONE;
        else
          state_nxt = FAIL;
      end
      DONE:    state_nxt = IDLE;
      FAIL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_start && (state != IDLE)) state_nxt = ARM;
    // The edge cycle itself is part of the pulse, hence a measuring state starts at 1.
    if (state_nxt != state)
      cnt_nxt = ((state_nxt == MEAS_LOW) || (state_nxt == MEAS_HIGH)) ? 17'd1 : 17'd0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      low_cnt  <= '0;
      high_cnt <= '0;
      cls_q    <= DEFAULT_RATE;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      low_cnt  <= low_nxt;
      high_cnt <= high_nxt;
      if (state == CHECK) cls_q <= cls_low[1:0];
    end
  end

  // The new rate takes effect on the same edge that ends the generator reset pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_bd_rate <= DEFAULT_RATE;
      o_locked  <= 1'b0;
    end else if (i_start) begin
      o_locked  <= 1'b0;
    end else if (state == DONE) begin
      o_bd_rate <= cls_q;
      o_locked  <= 1'b1;
    end
  end

  // A restart request suppresses the result pulses of the cycle it lands in.
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == DONE) && !i_start;
  assign o_gen_rst = (state == DONE) && !i_start;
  assign o_err     = (state == FAIL) && !i_start;

endmodule
